divider_8bit_seq: RTL and testbench

Multi-cycle unsigned restoring divider for the Full Nibble Processor ALU. It computes the quotient and remainder of two WIDTH-bit operands using one trial subtraction per clock cycle. It sits next to the combinational adder path in the execute stage. A start/busy/done handshake stalls the control unit until the result is valid.

---
 rtl/proc_pkg.sv | 18 +
 rtl/sub_nbit_borrow.sv | 15 +
 rtl/divider_8bit_seq.sv | 135 +++++++++++++
 tb/tb_divider_8bit_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the Full Nibble Processor execute stage.
// Holds the divider FSM encoding and the default datapath width.
package proc_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Bits needed to count 0..w-1; never less than one bit.
    function automatic int unsigned count_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sub_nbit_borrow.sv
// Combinational N-bit subtractor used for the divider's trial subtraction.
// Produces the wrapped difference and a borrow flag (a < b).
module sub_nbit_borrow #(
    parameter int unsigned Width = 9
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] diff,
    output logic             borrow
);

    assign diff   = a - b;
    assign borrow = (a < b);

endmodule

// File: rtl/divider_8bit_seq.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, results held until the next operation completes.
module divider_8bit_seq
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int unsigned CntW = count_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_e state_q, state_d;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   pr_shift;
    logic [WIDTH:0]   trial;
    logic             trial_borrow;
    logic [WIDTH:0]   pr_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder is always below the divisor, so its MSB stays zero.
    logic unused_pr_msb;
    assign unused_pr_msb = pr_q[WIDTH];

    assign pr_shift = {pr_q[WIDTH-1:0], q_q[WIDTH-1]};

    sub_nbit_borrow #(
        .Width(WIDTH + 1)
    ) u_trial_sub (
        .a     (pr_shift),
        .b     ({1'b0, div_q}),
        .diff  (trial),
        .borrow(trial_borrow)
    );

    always_comb begin
        pr_next = trial_borrow ? pr_shift : trial;
        q_next  = {q_q[WIDTH-2:0], ~trial_borrow};
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        pr_d        = pr_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        q_d     = dividend;
                        div_d   = divisor;
                        pr_d    = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                q_d   = q_next;
                pr_d  = pr_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Publish results on the edge that enters DONE.
                    quotient_d  = q_next;
                    remainder_d = pr_next[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            q_q         <= '0;
            pr_q        <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            pr_q        <= pr_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Directed self-checking bench for divider_8bit_seq (8-bit and 4-bit instances).
module tb_divider_8bit_seq;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] dividend8, divisor8;
    logic       busy8, done8, dbz8;
    logic [7:0] quotient8, remainder8;

    logic       start4;
    logic [3:0] dividend4, divisor4;
    logic       busy4, done4, dbz4;
    logic [3:0] quotient4, remainder4;

    int n_tests;
    int n_fail;

    divider_8bit_seq #(
        .WIDTH(8)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .dividend (dividend8),
        .divisor  (divisor8),
        .busy     (busy8),
        .done     (done8),
        .quotient (quotient8),
        .remainder(remainder8),
        .dbz      (dbz8)
    );

    divider_8bit_seq #(
        .WIDTH(4)
    ) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .dividend (dividend4),
        .divisor  (divisor4),
        .busy     (busy4),
        .done     (done4),
        .quotient (quotient4),
        .remainder(remainder4),
        .dbz      (dbz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one 8-bit division from a negedge; returns at the negedge where done is seen.
    // poke_at >= 0 re-pulses start with 9/3 at that loop index (must be ignored).
    task automatic div8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input int poke_at,
                        input string tag);
        int         acc, done_at, busy_n;
        logic [7:0] q_s, r_s;
        logic       dbz_s;
        acc     = -1;
        done_at = -1;
        busy_n  = 0;
        q_s     = '0;
        r_s     = '0;
        dbz_s   = 1'b0;
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            @(negedge clk);
            if (busy8) busy_n++;
            if ((busy8 || done8) && acc < 0) begin
                acc       = i;
                // Operands are free to change once captured.
                dividend8 = ~a;
                divisor8  = ~b;
            end
            if (done8) begin
                done_at = i;
                q_s     = quotient8;
                r_s     = remainder8;
                dbz_s   = dbz8;
            end
            if (acc >= 0) start8 = 1'b0;
            if (i == poke_at) begin
                start8    = 1'b1;
                dividend8 = 8'd9;
                divisor8  = 8'd3;
            end
        end
        start8 = 1'b0;
        check_eq({tag, " done seen"}, 32'(done_at >= 0), 32'd1);
        check_eq({tag, " latency"}, 32'(done_at - acc), edbz ? 32'd0 : 32'd8);
        check_eq({tag, " busy cycles"}, 32'(busy_n), edbz ? 32'd0 : 32'd8);
        check_eq({tag, " quotient"}, 32'(q_s), 32'(eq));
        check_eq({tag, " remainder"}, 32'(r_s), 32'(er));
        check_eq({tag, " dbz"}, 32'(dbz_s), 32'(edbz));
    endtask

    // After done: no further done/busy, results held stable.
    task automatic idle_check(input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                              input string tag);
        int done_n, busy_n, unstable;
        done_n   = 0;
        busy_n   = 0;
        unstable = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done8) done_n++;
            if (busy8) busy_n++;
            if (quotient8 !== eq || remainder8 !== er || dbz8 !== edbz) unstable++;
        end
        check_eq({tag, " extra done"}, 32'(done_n), 32'd0);
        check_eq({tag, " idle busy"}, 32'(busy_n), 32'd0);
        check_eq({tag, " held results"}, 32'(unstable), 32'd0);
    endtask

    initial begin
        int acc, done_at, busy_n, done_n;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start8    = 1'b0;
        dividend8 = '0;
        divisor8  = '0;
        start4    = 1'b0;
        dividend4 = '0;
        divisor4  = '0;

        repeat (2) @(negedge clk);
        check_eq("reset busy", 32'(busy8), 32'd0);
        check_eq("reset done", 32'(done8), 32'd0);
        check_eq("reset quotient", 32'(quotient8), 32'd0);
        check_eq("reset remainder", 32'(remainder8), 32'd0);
        check_eq("reset dbz", 32'(dbz8), 32'd0);
        check_eq("reset w4 outputs", 32'({busy4, done4, dbz4, quotient4, remainder4}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        div8(8'd145, 8'd66, 8'd2, 8'd13, 1'b0, -1, "145/66");
        idle_check(8'd2, 8'd13, 1'b0, "145/66");

        div8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, -1, "255/1");
        div8(8'd27, 8'd37, 8'd0, 8'd27, 1'b0, -1, "27/37 b2b");
        idle_check(8'd0, 8'd27, 1'b0, "27/37");

        div8(8'd254, 8'd0, 8'hFF, 8'd254, 1'b1, -1, "254/0");
        idle_check(8'hFF, 8'd254, 1'b1, "254/0");

        div8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 3, "200/7 poke");
        idle_check(8'd28, 8'd4, 1'b0, "200/7");

        // Asynchronous reset during the 4th RUN cycle.
        dividend8 = 8'd100;
        divisor8  = 8'd9;
        start8    = 1'b1;
        @(negedge clk);
        check_eq("rst-run busy", 32'(busy8), 32'd1);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst-run busy", 32'(busy8), 32'd0);
        check_eq("rst-run done", 32'(done8), 32'd0);
        check_eq("rst-run quotient", 32'(quotient8), 32'd0);
        check_eq("rst-run remainder", 32'(remainder8), 32'd0);
        check_eq("rst-run dbz", 32'(dbz8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) done_n++;
        end
        check_eq("rst-run no done", 32'(done_n), 32'd0);

        div8(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, -1, "100/9");
        idle_check(8'd11, 8'd1, 1'b0, "100/9");

        // 4-bit instance.
        dividend4 = 4'd13;
        divisor4  = 4'd4;
        start4    = 1'b1;
        acc       = -1;
        done_at   = -1;
        busy_n    = 0;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            @(negedge clk);
            if (busy4) busy_n++;
            if ((busy4 || done4) && acc < 0) acc = i;
            if (done4) done_at = i;
            if (acc >= 0) start4 = 1'b0;
        end
        start4 = 1'b0;
        check_eq("w4 13/4 done seen", 32'(done_at >= 0), 32'd1);
        check_eq("w4 13/4 latency", 32'(done_at - acc), 32'd4);
        check_eq("w4 13/4 busy cycles", 32'(busy_n), 32'd4);
        check_eq("w4 13/4 quotient", 32'(quotient4), 32'd3);
        check_eq("w4 13/4 remainder", 32'(remainder4), 32'd1);
        check_eq("w4 13/4 dbz", 32'(dbz4), 32'd0);
        @(negedge clk);
        check_eq("w4 13/4 done pulse", 32'(done4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
